// File: rtl/store_bmp_if.sv
// Stream/RAM signal bundle for store_bmp; slave is the store_bmp side, master the RAM/sink/controller side.
interface store_bmp_if #(
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 20
);
    logic                  in_valid;
    logic [BYTE_WIDTH-1:0] RAM_Q;
    logic                  RAM_rd;
    logic [ADDR_WIDTH-1:0] RAM_addr;
    logic                  out_valid;
    logic                  out_ready;
    logic [BYTE_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    modport slave (
        input  in_valid, RAM_Q, out_ready,
        output RAM_rd, RAM_addr, out_valid, out_data, out_last, busy, done
    );

    modport master (
        output in_valid, RAM_Q, out_ready,
        input  RAM_rd, RAM_addr, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/store_bmp.sv
// store_bmp: reads the image RAM back from address 0 to TOTAL_SIZE-1 onto a valid/ready byte stream.
// Defining STORE_BMP_CHECKSUM_EN adds a 32-bit running sum of transferred bytes on port checksum.
//
// state  | meaning
// IDLE   | waiting for in_valid
// FETCH  | issuing RAM reads while the FIFO plus in-flight read has room
// DRAIN  | all reads issued; emptying the FIFO
// FINISH | one-cycle done pulse
module store_bmp #(
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 20,
    parameter int TOTAL_SIZE = 2**20-1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    store_bmp_if.slave bus
`ifdef STORE_BMP_CHECKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] SIZE  = ADDR_WIDTH'(TOTAL_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(TOTAL_SIZE - 1);
    localparam logic [CW:0]           DEPTH = (CW+1)'(FIFO_DEPTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  inflight_q;
    logic [BYTE_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  start, rd, push, pop, last_xfer;

    assign push      = inflight_q;
    assign pop       = bus.out_valid && bus.out_ready;
    assign last_xfer = pop && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        rd      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    start   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // the in-flight read reserves a FIFO slot so the push can never overflow
                rd = (addr_q < SIZE) && (({1'b0, count_q} + (CW+1)'(inflight_q)) < DEPTH);
                if (rd && (addr_q == LAST)) state_d = DRAIN;
            end
            DRAIN: begin
                if (last_xfer) state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (start) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (rd) addr_q <= addr_q + ADDR_WIDTH'(1);
            inflight_q <= rd;
            if (push) begin
                mem_q[wr_ptr_q] <= bus.RAM_Q;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                cnt_q    <= cnt_q + ADDR_WIDTH'(1);
            end
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

`ifdef STORE_BMP_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     checksum <= '0;
        else if (start) checksum <= '0;
        else if (pop)   checksum <= checksum + 32'(bus.out_data);
    end
`endif

    assign bus.RAM_rd    = rd;
    assign bus.RAM_addr  = addr_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.out_last  = bus.out_valid && (cnt_q == LAST);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == FINISH);
endmodule

// File: tb/tb_store_bmp.sv
// Bench for store_bmp: random/directed backpressure against a stream-order model, plus a TOTAL_SIZE=1 instance.
module tb_store_bmp;
    localparam int TS = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    store_bmp_if #(.BYTE_WIDTH(8), .ADDR_WIDTH(20)) b16 ();
    store_bmp_if #(.BYTE_WIDTH(8), .ADDR_WIDTH(20)) b1 ();

`ifdef STORE_BMP_CHECKSUM_EN
    logic [31:0] cs16, cs1;
`endif

    store_bmp #(.BYTE_WIDTH(8), .ADDR_WIDTH(20), .TOTAL_SIZE(TS), .FIFO_DEPTH(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .bus(b16.slave)
`ifdef STORE_BMP_CHECKSUM_EN
        , .checksum(cs16)
`endif
    );

    store_bmp #(.BYTE_WIDTH(8), .ADDR_WIDTH(20), .TOTAL_SIZE(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave)
`ifdef STORE_BMP_CHECKSUM_EN
        , .checksum(cs1)
`endif
    );

    byte unsigned img [TS];

    // synchronous-read RAM models
    always @(posedge clk) if (b16.RAM_rd) b16.RAM_Q <= img[b16.RAM_addr[3:0]];
    always @(posedge clk) if (b1.RAM_rd)  b1.RAM_Q  <= (b1.RAM_addr == 20'd0) ? 8'hA5 : 8'h00;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // stream model: expected byte order, done timing, read window and stall stability
    bit          m_busy, m_done_due, m_hold, m_seen_valid;
    logic [7:0]  m_hold_data;
    int          m_idx, m_reads, m_cyc, m_dones, m_done_cyc;
    logic [31:0] m_sum;

    always @(negedge clk) begin
        bit xfer, nd, st;
        if (!rst_n) begin
            check("rst_busy", 64'(b16.busy), 0);
            check("rst_done", 64'(b16.done), 0);
            check("rst_valid", 64'(b16.out_valid), 0);
            check("rst_last", 64'(b16.out_last), 0);
            check("rst_data", 64'(b16.out_data), 0);
            check("rst_rd", 64'(b16.RAM_rd), 0);
            check("rst_addr", 64'(b16.RAM_addr), 0);
`ifdef STORE_BMP_CHECKSUM_EN
            check("rst_checksum", 64'(cs16), 0);
`endif
            m_busy = 0; m_done_due = 0; m_hold = 0; m_seen_valid = 0;
            m_idx = 0; m_reads = 0; m_cyc = 0; m_sum = 0;
        end else begin
            if (m_busy) m_cyc++;
            check("busy", 64'(b16.busy), 64'(m_busy));
            check("done", 64'(b16.done), 64'(m_done_due));
            if (m_done_due) begin
                m_dones++;
                m_done_cyc = m_cyc;
`ifdef STORE_BMP_CHECKSUM_EN
                check("checksum", 64'(cs16), 64'(m_sum));
`endif
            end
            if (!m_busy) check("idle_valid", 64'(b16.out_valid), 0);
            if (m_busy && b16.out_valid && !m_seen_valid) begin
                check("first_valid_latency", 64'(m_cyc), 3);
                m_seen_valid = 1;
            end
            if (m_hold) begin
                check("stall_valid", 64'(b16.out_valid), 1);
                check("stall_data", 64'(b16.out_data), 64'(m_hold_data));
            end
            if (b16.RAM_rd) begin
                check("rd_addr", 64'(b16.RAM_addr), 64'(m_reads));
                check("rd_range", 64'(m_reads < TS), 1);
                check("rd_window", 64'((m_reads + 1 - m_idx) <= 4), 1);
                m_reads++;
            end
            if (b16.out_valid) check("last", 64'(b16.out_last), 64'(m_idx == TS - 1));
            xfer = b16.out_valid && b16.out_ready;
            nd = 0;
            if (xfer) begin
                if (m_idx >= TS) check("extra_byte", 64'(m_idx), TS - 1);
                else begin
                    check("data", 64'(b16.out_data), 64'(img[m_idx]));
                    m_sum += 32'(img[m_idx]);
                    nd = (m_idx == TS - 1);
                end
                m_idx++;
            end
            m_hold = b16.out_valid && !b16.out_ready;
            m_hold_data = b16.out_data;
            st = !m_busy && b16.in_valid;
            if (m_done_due) m_busy = 0;
            m_done_due = nd;
            if (st) begin
                m_busy = 1; m_cyc = 0; m_idx = 0; m_reads = 0; m_sum = 0;
                m_seen_valid = 0; m_hold = 0;
            end
        end
    end

    // mode: 0 ready high, 1 toggle, 2 random (with junk in_valid), 3 low for 20 cycles after start
    task automatic run(input int mode, input int revalid_at, input int abort_at);
        int d0, n;
        bit released;
        d0 = m_dones;
        n = 0;
        released = 0;
        @(posedge clk); #1;
        b16.in_valid  = 1'b1;
        b16.out_ready = (mode != 3);
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        while (m_dones == d0 && n < 400) begin
            n++;
            case (mode)
                0: b16.out_ready = 1'b1;
                1: b16.out_ready = ~b16.out_ready;
                2: b16.out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (!released && m_cyc >= 20) begin
                        check("stall_addr", 64'(b16.RAM_addr), 4);
                        check("stall_head", 64'(b16.out_data), 1);
                        check("stall_head_valid", 64'(b16.out_valid), 1);
                        released = 1;
                    end
                    b16.out_ready = released;
                end
            endcase
            b16.in_valid = (n == revalid_at) || (mode == 2 && $urandom_range(0, 7) == 0);
            if (abort_at > 0 && m_idx == abort_at) begin
                b16.in_valid = 1'b0;
                rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        b16.in_valid = 1'b0;
        if (n >= 400) check("done_timeout", 0, 1);
        check("byte_count", 64'(m_idx), TS);
        repeat (3) @(posedge clk);
        #1 check("done_pulses", 64'(m_dones - d0), 1);
    endtask

    initial begin
        int vcyc, dcyc, dn, rdn;
        logic [7:0] v1data;
        logic v1last;
        rst_n = 1'b0;
        m_dones = 0;
        b16.in_valid = 0; b16.out_ready = 0;
        b1.in_valid = 0;  b1.out_ready = 0;
        for (int i = 0; i < TS; i++) img[i] = 8'(i + 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run(0, 0, 0);
        check("t1_done_cycle", 64'(m_done_cyc), TS + 3);
        check("t1_model_sum", 64'(m_sum), 136);
`ifdef STORE_BMP_CHECKSUM_EN
        check("t1_checksum", 64'(cs16), 136);
`endif
        run(1, 0, 0);
        run(3, 0, 0);
        run(0, 5, 0);
        run(2, 0, 8);
        run(0, 0, 0);
`ifdef STORE_BMP_CHECKSUM_EN
        check("t5_checksum", 64'(cs16), 136);
`endif
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < TS; i++) img[i] = 8'($urandom_range(0, 255));
            run(2, int'($urandom_range(1, 10)), 0);
        end

        vcyc = -1; dcyc = -1; dn = 0; rdn = 0; v1data = 0; v1last = 0;
        b1.out_ready = 1'b1;
        @(posedge clk); #1 b1.in_valid = 1'b1;
        @(posedge clk); #1 b1.in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (b1.RAM_rd) rdn++;
            if (b1.out_valid && vcyc < 0) begin
                vcyc = k; v1data = b1.out_data; v1last = b1.out_last;
            end
            if (b1.done) begin
                dn++;
                if (dcyc < 0) dcyc = k;
            end
        end
        check("ts1_valid_cycle", 64'(vcyc), 3);
        check("ts1_data", 64'(v1data), 8'hA5);
        check("ts1_last", 64'(v1last), 1);
        check("ts1_done_cycle", 64'(dcyc), 4);
        check("ts1_done_pulses", 64'(dn), 1);
        check("ts1_reads", 64'(rdn), 1);
        check("ts1_addr_hold", 64'(b1.RAM_addr), 1);
`ifdef STORE_BMP_CHECKSUM_EN
        check("ts1_checksum", 64'(cs1), 165);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_bmp.md
Name: store_bmp

Overview:
- Reverse path of the BMP loader: after the image buffer RAM is filled (or processed), this block reads it back byte by byte, from address 0 to TOTAL_SIZE-1.
- Each byte is presented on a valid/ready byte stream that feeds the file-dump sink or the next stage.
- A small prefetch FIFO hides the 1-cycle RAM read latency and absorbs backpressure.

Parameters:
- BYTE_WIDTH, 8: data width of RAM word and stream byte.
- ADDR_WIDTH, 20: RAM address width.
- TOTAL_SIZE, 2**20-1: bytes per image, header included; must be >=1 and <2**ADDR_WIDTH.
- FIFO_DEPTH, 4: prefetch FIFO entries; power of two, >=3 (required for 1 byte/cycle).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  start request, sampled only in IDLE.
- RAM_Q  input  BYTE_WIDTH  RAM read data, valid the cycle after RAM_rd.
- RAM_rd  output  1  RAM read enable, combinational from state/counters.
- RAM_addr  output  ADDR_WIDTH  registered read address.
- out_valid  output  1  out_data holds a byte.
- out_ready  input  1  sink accepts byte.
- out_data  output  BYTE_WIDTH  FIFO head byte.
- out_last  output  1  high with the byte at index TOTAL_SIZE-1.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset, asynchronous: state=IDLE, RAM_addr=0, RAM_rd=0, FIFO empty, inflight=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, byte counter=0.
- States are IDLE, FETCH, DRAIN, FINISH.
- IDLE -> FETCH when in_valid=1. On entry: RAM_addr=0, byte counter=0, FIFO cleared.
- FETCH:
  - RAM_rd = (RAM_addr < TOTAL_SIZE) && (fifo_count + inflight < FIFO_DEPTH).
  - Each RAM_rd increments RAM_addr at the clock edge and sets inflight=1 for the next cycle.
  - RAM_Q is pushed into the FIFO in the cycle where inflight=1.
  - Go to DRAIN when the issued read has RAM_addr == TOTAL_SIZE-1.
- DRAIN: no reads; capture the last in-flight byte. Go to FINISH on the cycle the byte with counter==TOTAL_SIZE-1 transfers.
- FINISH: done=1 for exactly one cycle, then IDLE. RAM_addr holds TOTAL_SIZE until the next start.
- Transfer rule: a byte transfers when out_valid && out_ready.
  - out_valid = FIFO not empty; out_data = FIFO head.
  - The head is stable while out_valid && !out_ready; it never changes without a transfer.
- Byte counter increments per transfer. out_last = out_valid && counter == TOTAL_SIZE-1.
- Latency: in_valid sampled at edge N. RAM_rd=1 with addr 0 in cycle N+1. Byte pushed at edge N+2. out_valid=1 in cycle N+3.
- Throughput: with out_ready held high, one byte per cycle; total start-to-done = TOTAL_SIZE+3 cycles.
- Simultaneous push and pop: both occur; fifo_count unchanged. The FIFO never overflows, guaranteed by the inflight reservation.
- in_valid while busy: ignored, no restart.
- out_ready low for any duration: reads stall once the FIFO plus in-flight count reaches FIFO_DEPTH. No byte is lost or duplicated.
- TOTAL_SIZE=1: single read; FETCH->DRAIN immediately; out_last on the first byte.
- Reset mid-operation: immediate return to reset values; the partial stream is abandoned and no done pulse is generated.

Optional Feature:
- Macro: STORE_BMP_CHECKSUM_EN.
- Defined:
  - Adds output checksum [31:0], cleared to 0 on reset and on the IDLE->FETCH transition.
  - Adds each transferred byte, zero-extended, modulo 2**32.
  - Final value is valid when done=1 and held until the next start.
- Undefined: port and adder absent; all other behaviour identical.

Test Plan:
- TOTAL_SIZE=16, RAM[i]=i+1, out_ready=1, pulse in_valid -> out_valid first at start+3; bytes 1..16 on consecutive cycles; out_last with byte 16; done at the cycle after; checksum=136.
- Same image, out_ready toggling 1,0,1,0 -> exactly 16 transfers, values 1..16 in order, out_data stable during every stall; done after the 16th transfer.
- out_ready=0 for 20 cycles after start -> RAM_rd stops after FIFO_DEPTH reads (RAM_addr=4); out_data=1 held; release ready -> 1..16 delivered.
- in_valid re-asserted at cycle 5 of an active transfer -> ignored; still exactly 16 bytes and one done pulse.
- rst_n low at the 8th transfer, then a new start -> outputs return to reset values; restart delivers 1..16 from address 0; checksum=136.
- TOTAL_SIZE=1, RAM[0]=0xA5 -> single byte 0xA5 with out_last=1; done next cycle; checksum=165.
